// File: rtl/evm_pkg.sv
// Shared types and helpers for the multi-candidate voting FSM.
package evm_pkg;

   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      S_IDLE,
      S_READY,
      S_SELECTED,
      S_CONFIRM,
      S_COMMIT,
      S_LOCKED,
      S_CLOSED
   } state_t;

   function automatic logic [31:0] sat_inc(
      input logic [31:0] v,
      input logic [31:0] vmax
   );
      return (v >= vmax) ? vmax : v + 32'd1;
   endfunction

endpackage

// File: rtl/evm_edge_det.sv
// Registered rising-edge detector, one pulse per low-to-high level change.
module evm_edge_det #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_lvl,
   output logic [W-1:0] o_rise
);

   logic [W-1:0] r_d;
   logic [W-1:0] r_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d    <= '0;
         r_rise <= '0;
      end else begin
         r_d    <= i_lvl;
         r_rise <= i_lvl & ~r_d;
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/evm_fsm_multi.sv
// N-candidate voting FSM with two-step confirm, timeout and deferred close.
module evm_fsm_multi
   import evm_pkg::*;
#(
   parameter int NUM_CAND    = 4,
   parameter int CAND_W      = $clog2(NUM_CAND),
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 1000,
   parameter int LOCK_CYC    = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      close,
   input  logic [CAND_W-1:0]         vote,
   input  logic                      select,
   input  logic                      confirm,
   input  logic                      cancel,
   input  logic [CAND_W-1:0]         rd_idx,
   output logic                      ready,
   output logic                      locked,
   output logic                      closed,
   output logic [NUM_CAND-1:0]       led_state,
   output logic [NUM_CAND*CNT_W-1:0] counts,
   output logic [CNT_W+CAND_W-1:0]   total,
   output logic [CNT_W-1:0]          rd_count,
   output logic                      err,
   output logic                      timeout
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam int LK_W  = $clog2(LOCK_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [4:0] w_rise;
   logic       w_start, w_close, w_sel, w_cfm, w_can;

   evm_edge_det #(.W(5)) u_edge (
      .clk    (clk),
      .rst_n  (reset),
      .i_lvl  ({cancel, confirm, select, close, start}),
      .o_rise (w_rise)
   );

   assign {w_can, w_cfm, w_sel, w_close, w_start} = w_rise;

   state_t               r_st, w_nxt;
   logic [TMR_W-1:0]     r_tmr;
   logic [LK_W-1:0]      r_lk;
   logic [CAND_W-1:0]    r_lat;
   logic                 r_pend;
   logic [CNT_W-1:0]     r_cnt [NUM_CAND];
   logic [CNT_W+CAND_W-1:0] r_tot;
   logic                 r_ready, r_locked, r_closed;
   logic                 r_err, r_to;
   logic [NUM_CAND-1:0]  r_led;

   logic                 w_vok, w_tmo, w_lk_done, w_sat;
   logic                 w_tmr_clr, w_tmr_inc, w_latch;
   logic                 w_err, w_to, w_inc, w_pend_set;
   logic [CAND_W-1:0]    w_lat_nxt;

   assign w_vok     = int'(vote) < NUM_CAND;
   assign w_tmo     = r_tmr == TMR_W'(TIMEOUT_CYC - 1);
   assign w_lk_done = r_lk == LK_W'(LOCK_CYC - 1);
   assign w_sat     = r_cnt[r_lat] == CNT_MAX;
   assign w_lat_nxt = w_latch ? vote : r_lat;

   always_comb begin
      w_nxt     = r_st;
      w_tmr_clr = 1'b0;
      w_tmr_inc = 1'b0;
      w_latch   = 1'b0;
      w_err     = 1'b0;
      w_to      = 1'b0;
      w_inc     = 1'b0;
      unique case (r_st)
         S_IDLE: begin
            if (w_start) w_nxt = S_READY;
         end
         S_READY: begin
            if (w_close || r_pend) begin
               w_nxt = S_CLOSED;
            end else if (w_sel && w_vok) begin
               w_nxt     = S_SELECTED;
               w_latch   = 1'b1;
               w_tmr_clr = 1'b1;
            end else begin
               w_err = w_sel;
            end
         end
         S_SELECTED: begin
            if (w_can) begin
               w_nxt = S_READY;
            end else if (w_tmo) begin
               w_nxt = S_READY;
               w_to  = 1'b1;
            end else if (w_cfm) begin
               w_nxt     = S_CONFIRM;
               w_tmr_clr = 1'b1;
            end else if (w_sel && w_vok) begin
               w_latch   = 1'b1;
               w_tmr_clr = 1'b1;
            end else begin
               w_err     = w_sel;
               w_tmr_inc = 1'b1;
            end
         end
         S_CONFIRM: begin
            if (w_can) begin
               w_nxt = S_READY;
            end else if (w_tmo) begin
               w_nxt = S_READY;
               w_to  = 1'b1;
            end else if (w_cfm) begin
               w_nxt = S_COMMIT;
            end else begin
               w_tmr_inc = 1'b1;
            end
         end
         S_COMMIT: begin
            w_inc = 1'b1;
            w_nxt = S_LOCKED;
         end
         S_LOCKED: begin
            if (w_lk_done) w_nxt = S_READY;
         end
         S_CLOSED: w_nxt = S_CLOSED;
         default:  w_nxt = S_IDLE;
      endcase
   end

   // Close arriving mid-vote waits until the FSM is back in READY.
   assign w_pend_set = w_close &&
      (r_st == S_SELECTED || r_st == S_CONFIRM ||
       r_st == S_COMMIT   || r_st == S_LOCKED);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_st     <= S_IDLE;
         r_tmr    <= '0;
         r_lk     <= '0;
         r_lat    <= '0;
         r_pend   <= 1'b0;
         r_tot    <= '0;
         r_ready  <= 1'b0;
         r_locked <= 1'b0;
         r_closed <= 1'b0;
         r_err    <= 1'b0;
         r_to     <= 1'b0;
         r_led    <= '0;
         for (int i = 0; i < NUM_CAND; i++) r_cnt[i] <= '0;
      end else begin
         r_st  <= w_nxt;
         r_lat <= w_lat_nxt;
         if (w_tmr_clr)      r_tmr <= '0;
         else if (w_tmr_inc) r_tmr <= r_tmr + TMR_W'(1);
         if (r_st == S_LOCKED) r_lk <= r_lk + LK_W'(1);
         else                  r_lk <= '0;
         if (w_pend_set) r_pend <= 1'b1;
         if (w_inc && !w_sat) begin
            r_cnt[r_lat] <= CNT_W'(sat_inc(32'(r_cnt[r_lat]), 32'(CNT_MAX)));
            r_tot        <= r_tot + (CNT_W+CAND_W)'(1);
         end
         r_ready  <= w_nxt == S_READY;
         r_locked <= w_nxt == S_LOCKED;
         r_closed <= w_nxt == S_CLOSED;
         r_err    <= w_err;
         r_to     <= w_to;
         if (w_nxt == S_SELECTED || w_nxt == S_CONFIRM)
            r_led <= NUM_CAND'(1) << w_lat_nxt;
         else
            r_led <= '0;
      end
   end

   for (genvar g = 0; g < NUM_CAND; g++) begin : g_cnt
      assign counts[g*CNT_W +: CNT_W] = r_cnt[g];
   end

   assign ready     = r_ready;
   assign locked    = r_locked;
   assign closed    = r_closed;
   assign led_state = r_led;
   assign total     = r_tot;
   assign err       = r_err;
   assign timeout   = r_to;
   assign rd_count  = (r_closed && int'(rd_idx) < NUM_CAND) ?
                      r_cnt[rd_idx] : '0;

endmodule

// File: tb/tb_evm_fsm_multi.sv
// Random and directed bench for evm_fsm_multi against a behavioural model.
module tb_evm_fsm_multi;

   localparam int NC  = 3;
   localparam int CW  = 2;
   localparam int NW  = 2;
   localparam int TO  = 1000;
   localparam int LK  = 4;
   localparam int MAXC = (1 << NW) - 1;

   localparam int M_IDLE = 10, M_RDY = 11, M_SEL = 12, M_CNF = 13;
   localparam int M_COM = 14, M_LCK = 15, M_CLS = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 0, close = 0, select = 0, confirm = 0, cancel = 0;
   logic [CW-1:0] vote = '0;
   logic [CW-1:0] rd_idx = '0;
   logic ready, locked, closed, err, timeout;
   logic [NC-1:0] led_state;
   logic [NC*NW-1:0] counts;
   logic [NW+CW-1:0] total;
   logic [NW-1:0] rd_count;

   evm_fsm_multi #(
      .NUM_CAND(NC), .CNT_W(NW), .TIMEOUT_CYC(TO), .LOCK_CYC(LK)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .close(close),
      .vote(vote), .select(select), .confirm(confirm),
      .cancel(cancel), .rd_idx(rd_idx), .ready(ready),
      .locked(locked), .closed(closed), .led_state(led_state),
      .counts(counts), .total(total), .rd_count(rd_count),
      .err(err), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int n_tot = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   int m_st, m_lat, m_idle, m_lk, m_tot;
   int m_cnt [NC];
   bit m_pend, m_err, m_to;
   logic [4:0] h1, h2;

   task automatic model_reset();
      m_st = M_IDLE; m_lat = 0; m_idle = 0; m_lk = 0; m_tot = 0;
      m_pend = 0; m_err = 0; m_to = 0; h1 = '0; h2 = '0;
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
   endtask

   task automatic model_step();
      bit e_st, e_cl, e_se, e_cf, e_ca, v_ok;
      int st0;
      if (!reset) begin
         model_reset();
         return;
      end
      e_st = h1[0] & ~h2[0];
      e_cl = h1[1] & ~h2[1];
      e_se = h1[2] & ~h2[2];
      e_cf = h1[3] & ~h2[3];
      e_ca = h1[4] & ~h2[4];
      v_ok = int'(vote) < NC;
      st0 = m_st;
      m_err = 0;
      m_to = 0;
      case (m_st)
         M_IDLE: if (e_st) m_st = M_RDY;
         M_RDY: begin
            if (e_cl || m_pend) m_st = M_CLS;
            else if (e_se && v_ok) begin
               m_st = M_SEL; m_lat = int'(vote); m_idle = 0;
            end else if (e_se) m_err = 1;
         end
         M_SEL, M_CNF: begin
            if (e_ca) m_st = M_RDY;
            else if (m_idle == TO - 1) begin
               m_st = M_RDY; m_to = 1;
            end else if (e_cf) begin
               m_st = (m_st == M_SEL) ? M_CNF : M_COM;
               m_idle = 0;
            end else if (m_st == M_SEL && e_se && v_ok) begin
               m_lat = int'(vote); m_idle = 0;
            end else begin
               m_err = (m_st == M_SEL) && e_se;
               m_idle++;
            end
         end
         M_COM: begin
            if (m_cnt[m_lat] < MAXC) begin
               m_cnt[m_lat]++;
               m_tot++;
            end
            m_st = M_LCK;
            m_lk = 0;
         end
         M_LCK: begin
            m_lk++;
            if (m_lk == LK) m_st = M_RDY;
         end
         default: ;
      endcase
      if (e_cl && (st0 == M_SEL || st0 == M_CNF ||
                   st0 == M_COM || st0 == M_LCK)) m_pend = 1;
      h2 = h1;
      h1 = {cancel, confirm, select, close, start};
   endtask

   task automatic check_all();
      logic [NC*NW-1:0] e_cnt;
      logic [NC-1:0] e_led;
      int e_rd;
      for (int i = 0; i < NC; i++) e_cnt[i*NW +: NW] = NW'(m_cnt[i]);
      e_led = (m_st == M_SEL || m_st == M_CNF) ? NC'(1 << m_lat) : '0;
      e_rd = (m_st == M_CLS && int'(rd_idx) < NC) ?
             m_cnt[int'(rd_idx)] : 0;
      chk("ready", 64'(ready), 64'(m_st == M_RDY));
      chk("locked", 64'(locked), 64'(m_st == M_LCK));
      chk("closed", 64'(closed), 64'(m_st == M_CLS));
      chk("led", 64'(led_state), 64'(e_led));
      chk("counts", 64'(counts), 64'(e_cnt));
      chk("total", 64'(total), 64'(m_tot));
      chk("err", 64'(err), 64'(m_err));
      chk("timeout", 64'(timeout), 64'(m_to));
      chk("rd_count", 64'(rd_count), 64'(e_rd));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic press(input int b);
      case (b)
         0: start = 1;
         1: close = 1;
         2: select = 1;
         3: confirm = 1;
         default: cancel = 1;
      endcase
      cyc();
      {start, close, select, confirm, cancel} = '0;
      cyc();
   endtask

   task automatic cast_vote(input int c);
      vote = CW'(c);
      press(2);
      press(3);
      press(3);
   endtask

   int k;

   initial begin
      model_reset();
      repeat (3) cyc();
      chk("rst_ready", 64'(ready), 0);
      chk("rst_counts", 64'(counts), 0);
      chk("rst_total", 64'(total), 0);
      chk("rst_closed", 64'(closed), 0);
      reset = 1;
      cyc();

      press(0);
      cast_vote(1);
      k = 0;
      repeat (10) begin cyc(); k += int'(locked); end
      chk("lock_len", 64'(k), 4);
      chk("v1_ready", 64'(ready), 1);
      chk("v1_cnt1", 64'(counts[NW +: NW]), 1);
      chk("v1_total", 64'(total), 1);

      vote = 2;
      press(2);
      k = 0;
      repeat (TO + 10) begin cyc(); k += int'(timeout); end
      chk("tmo_cnt", 64'(k), 1);
      chk("tmo_ready", 64'(ready), 1);
      chk("tmo_total", 64'(total), 1);

      vote = 3;
      select = 1;
      cyc();
      select = 0;
      k = 0;
      repeat (3) begin cyc(); k += int'(err); end
      chk("err_cnt", 64'(k), 1);
      chk("err_ready", 64'(ready), 1);

      vote = 0;
      press(2);
      confirm = 1;
      repeat (10) cyc();
      confirm = 0;
      repeat (3) cyc();
      chk("hold_led", 64'(led_state), 1);
      chk("hold_total", 64'(total), 1);
      press(4);
      chk("can_ready", 64'(ready), 1);
      chk("can_led", 64'(led_state), 0);

      repeat (5) begin cast_vote(0); repeat (6) cyc(); end
      chk("sat_cnt0", 64'(counts[NW-1:0]), 3);
      chk("sat_total", 64'(total), 4);

      vote = 2;
      press(2);
      press(3);
      press(1);
      press(3);
      repeat (8) cyc();
      chk("dc_closed", 64'(closed), 1);
      chk("dc_cnt2", 64'(counts[2*NW +: NW]), 1);
      rd_idx = 2;
      #1;
      chk("dc_rd", 64'(rd_count), 1);
      cyc();

      reset = 0;
      cyc();
      reset = 1;
      press(0);
      cast_vote(1);
      cyc();
      chk("ml_locked", 64'(locked), 1);
      #2 reset = 0;
      model_reset();
      #1;
      chk("ml_ready", 64'(ready), 0);
      chk("ml_locked0", 64'(locked), 0);
      chk("ml_counts", 64'(counts), 0);
      chk("ml_total", 64'(total), 0);
      cyc();
      reset = 1;
      cyc();

      for (int i = 0; i < 5000; i++) begin
         start   = ($urandom_range(0, 49) == 0);
         close   = ($urandom_range(0, 2999) == 0);
         select  = ($urandom_range(0, 5) == 0);
         confirm = ($urandom_range(0, 3) == 0);
         cancel  = ($urandom_range(0, 29) == 0);
         vote    = CW'($urandom_range(0, 3));
         rd_idx  = CW'($urandom_range(0, 3));
         cyc();
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
